reservation_station: RTL and testbench
======================================

# reservation_station

Four-entry ALU reservation station directly downstream of the reorder buffer. It captures each dispatched operation with its operand values or producer tags, and snoops the ALU and memory result broadcasts to resolve pending operands. It issues one ready operation per cycle to the ALU through a valid/ready handshake, and back-pressures dispatch with `rs_full`.

## Interface
- `DEPTH`, 4: number of entries; fixed power of two, 2..8.
- `TAG_W`, 3: ROB tag width; tag 0 means "no dependency / no broadcast".
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `op_in`  in  5  dispatched opcode; 5'b11111 = no dispatch this cycle.
- `value1_in`, `value2_in`  in  32  operand values; meaningful only when the matching query is 0.
- `query1_in`, `query2_in`  in  TAG_W  producer ROB tag per operand; 0 = value already valid.
- `dest_in`  in  TAG_W  ROB tag of the dispatched operation; never 0.
- `alu_num`, `alu_value`  in  TAG_W / 32  ALU result broadcast; tag 0 = idle.
- `mem_num`, `mem_value`  in  TAG_W / 32  memory result broadcast; tag 0 = idle.
- `issue_ready`  in  1  ALU can accept an operation this cycle.
- `rs_full`  out  1  all DEPTH entries valid.
- `issue_valid`  out  1  issue registers hold an operation.
- `issue_op`  out  5  opcode of the issued operation.
- `issue_a`, `issue_b`  out  32  resolved operands.
- `issue_dest`  out  TAG_W  ROB tag of the issued operation.

## Operation
- Entry state: valid, op, v1, v2, q1, q2, dest.
- Dispatch:
  - When `op_in != 5'b11111` and at least one entry is free at the clock edge, write the lowest-index free entry.
  - When `op_in != 5'b11111` and the station is full, drop the dispatch silently. Upstream must honour `rs_full`.
- Capture forwarding on dispatch:
  - If `query1_in` (or `query2_in`) is non-zero and equals `alu_num` on the same edge, store `alu_value` and clear q.
  - Otherwise, if it equals `mem_num`, store `mem_value` and clear q.
- Wakeup: on every edge, each valid entry with `qX != 0` and `qX == alu_num` takes `alu_value` and clears qX; otherwise, if `qX == mem_num`, it takes `mem_value`. ALU has priority if both tags match (a legal producer never generates this case).
- Readiness: an entry is ready when it is valid with q1 == 0 and q2 == 0, using state before the edge.
- Issue select: the lowest-index ready entry.
- Issue register: loads on an edge where (`issue_valid` == 0 or `issue_ready` == 1) and a ready entry exists. The selected entry is freed on the same edge.
- Issue register hold: if `issue_valid` && !`issue_ready`, all issue outputs hold and no entry is selected.
- Issue register clear: `issue_valid` clears on an edge where `issue_valid && issue_ready` and no ready entry exists.
- `rs_full` is combinational from the valid bits: (count of valid == DEPTH).
- Reset: all entries invalid; `issue_valid` = 0; `issue_op` = 5'b11111; `issue_a` = `issue_b` = 0; `issue_dest` = 0; `rs_full` = 0. Reset mid-operation discards every entry and any pending issue immediately.

## Timing
- Dispatch of a fully ready operation at edge N: the entry is valid after N. It issues at edge N+1 (`issue_valid` high after N+1) if the issue register is free. Minimum dispatch-to-issue latency is 1 cycle.
- Broadcast at edge N that resolves the last pending operand: the entry is ready after N and issues at N+1.
- Same-edge dispatch plus matching broadcast: the operand is resolved at dispatch, so issue happens at N+1.
- Full, with an issue and a dispatch at the same edge: the freed slot is not visible to that dispatch, so the dispatch is dropped and `rs_full` falls after the edge. Dispatch into a slot freed at the same edge is not supported.
- Throughput: one issue per cycle while `issue_ready` stays high.
- Tags wrap within 1..2^TAG_W-1. The block never interprets tag ordering.

## Test plan
- Reset, then dispatch ADD (op 5'b00000), v1=5, v2=7, q1=q2=0, dest=3 at edge 1, with `issue_ready`=1 → after edge 2: `issue_valid`=1, op=0, a=5, b=7, dest=3.
- Dispatch with q1=4 and an idle broadcast; at a later edge `alu_num`=4, `alu_value`=0x1234 → issue one edge after the broadcast with a=0x1234. No issue occurs before the broadcast.
- Dispatch with q2=2 on the same edge as `mem_num`=2, `mem_value`=0xDEAD → issue at the next edge with b=0xDEAD.
- Hold `issue_ready`=0 and dispatch 4 ready ops → one op in the issue register, 3 entries valid, `rs_full`=0. A 5th dispatch makes `rs_full`=1, and a 6th dispatch is dropped. Release `issue_ready` → ops issue in entry-index order, one per cycle, and the dropped op never appears.
- Assert `rst` asynchronously mid-stream with 3 entries valid and `issue_valid`=1 → outputs reach reset values immediately, and no entry issues after `rst` deasserts.

Source files
------------

// File: rtl/reservation_station.sv
// Four-entry ALU reservation station: captures dispatched ops, snoops ALU/memory
// result broadcasts to resolve operand tags, and issues one ready op per cycle.
module reservation_station #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       op_in,
   input  logic [31:0]      value1_in,
   input  logic [31:0]      value2_in,
   input  logic [TAG_W-1:0] query1_in,
   input  logic [TAG_W-1:0] query2_in,
   input  logic [TAG_W-1:0] dest_in,
   input  logic [TAG_W-1:0] alu_num,
   input  logic [31:0]      alu_value,
   input  logic [TAG_W-1:0] mem_num,
   input  logic [31:0]      mem_value,
   input  logic             issue_ready,
   output logic             rs_full,
   output logic             issue_valid,
   output logic [4:0]       issue_op,
   output logic [31:0]      issue_a,
   output logic [31:0]      issue_b,
   output logic [TAG_W-1:0] issue_dest
);

   localparam logic [4:0] OP_NONE = 5'b11111;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [4:0]       op_q   [DEPTH];
   logic [4:0]       op_d   [DEPTH];
   logic [31:0]      v1_q   [DEPTH];
   logic [31:0]      v1_d   [DEPTH];
   logic [31:0]      v2_q   [DEPTH];
   logic [31:0]      v2_d   [DEPTH];
   logic [TAG_W-1:0] q1_q   [DEPTH];
   logic [TAG_W-1:0] q1_d   [DEPTH];
   logic [TAG_W-1:0] q2_q   [DEPTH];
   logic [TAG_W-1:0] q2_d   [DEPTH];
   logic [TAG_W-1:0] dest_q [DEPTH];
   logic [TAG_W-1:0] dest_d [DEPTH];

   logic             issue_valid_q, issue_valid_d;
   logic [4:0]       issue_op_q, issue_op_d;
   logic [31:0]      issue_a_q, issue_a_d;
   logic [31:0]      issue_b_q, issue_b_d;
   logic [TAG_W-1:0] issue_dest_q, issue_dest_d;

   logic [DEPTH-1:0] ready;
   logic [IDX_W-1:0] sel_idx, free_idx;
   logic             any_ready, any_free, do_issue, do_dispatch;

   // Both selects are lowest-index-first and look only at state before the edge,
   // so a slot freed by this edge's issue is not offered to this edge's dispatch.
   always_comb begin
      ready     = '0;
      sel_idx   = '0;
      free_idx  = '0;
      any_ready = 1'b0;
      any_free  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ready[i] = valid_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready[i]) begin
            sel_idx   = IDX_W'(i);
            any_ready = 1'b1;
         end
         if (!valid_q[i]) begin
            free_idx = IDX_W'(i);
            any_free = 1'b1;
         end
      end
      do_issue    = (!issue_valid_q || issue_ready) && any_ready;
      do_dispatch = (op_in != OP_NONE) && any_free;
   end

   always_comb begin
      valid_d = valid_q;
      op_d    = op_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      q1_d    = q1_q;
      q2_d    = q2_q;
      dest_d  = dest_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            if (q1_q[i] != '0 && q1_q[i] == alu_num) begin
               v1_d[i] = alu_value;
               q1_d[i] = '0;
            end else if (q1_q[i] != '0 && q1_q[i] == mem_num) begin
               v1_d[i] = mem_value;
               q1_d[i] = '0;
            end
            if (q2_q[i] != '0 && q2_q[i] == alu_num) begin
               v2_d[i] = alu_value;
               q2_d[i] = '0;
            end else if (q2_q[i] != '0 && q2_q[i] == mem_num) begin
               v2_d[i] = mem_value;
               q2_d[i] = '0;
            end
         end
      end

      if (do_issue) begin
         valid_d[sel_idx] = 1'b0;
      end

      // A broadcast on the dispatch edge is caught here, not by the wakeup above.
      if (do_dispatch) begin
         valid_d[free_idx] = 1'b1;
         op_d[free_idx]    = op_in;
         dest_d[free_idx]  = dest_in;
         v1_d[free_idx]    = value1_in;
         q1_d[free_idx]    = query1_in;
         v2_d[free_idx]    = value2_in;
         q2_d[free_idx]    = query2_in;
         if (query1_in != '0 && query1_in == alu_num) begin
            v1_d[free_idx] = alu_value;
            q1_d[free_idx] = '0;
         end else if (query1_in != '0 && query1_in == mem_num) begin
            v1_d[free_idx] = mem_value;
            q1_d[free_idx] = '0;
         end
         if (query2_in != '0 && query2_in == alu_num) begin
            v2_d[free_idx] = alu_value;
            q2_d[free_idx] = '0;
         end else if (query2_in != '0 && query2_in == mem_num) begin
            v2_d[free_idx] = mem_value;
            q2_d[free_idx] = '0;
         end
      end
   end

   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_op_d    = issue_op_q;
      issue_a_d     = issue_a_q;
      issue_b_d     = issue_b_q;
      issue_dest_d  = issue_dest_q;
      if (do_issue) begin
         issue_valid_d = 1'b1;
         issue_op_d    = op_q[sel_idx];
         issue_a_d     = v1_q[sel_idx];
         issue_b_d     = v2_q[sel_idx];
         issue_dest_d  = dest_q[sel_idx];
      end else if (issue_valid_q && issue_ready) begin
         issue_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q       <= '0;
         issue_valid_q <= 1'b0;
         issue_op_q    <= OP_NONE;
         issue_a_q     <= '0;
         issue_b_q     <= '0;
         issue_dest_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= OP_NONE;
            v1_q[i]   <= '0;
            v2_q[i]   <= '0;
            q1_q[i]   <= '0;
            q2_q[i]   <= '0;
            dest_q[i] <= '0;
         end
      end else begin
         valid_q       <= valid_d;
         issue_valid_q <= issue_valid_d;
         issue_op_q    <= issue_op_d;
         issue_a_q     <= issue_a_d;
         issue_b_q     <= issue_b_d;
         issue_dest_q  <= issue_dest_d;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= op_d[i];
            v1_q[i]   <= v1_d[i];
            v2_q[i]   <= v2_d[i];
            q1_q[i]   <= q1_d[i];
            q2_q[i]   <= q2_d[i];
            dest_q[i] <= dest_d[i];
         end
      end
   end

   assign rs_full     = &valid_q;
   assign issue_valid = issue_valid_q;
   assign issue_op    = issue_op_q;
   assign issue_a     = issue_a_q;
   assign issue_b     = issue_b_q;
   assign issue_dest  = issue_dest_q;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic, all
// cycles checked against a slot/queue-level reference model.
module tb_reservation_station;

   localparam int DEPTH = 4;
   localparam int TAG_W = 3;
   localparam logic [4:0] OP_NONE = 5'b11111;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       op_in;
   logic [31:0]      value1_in, value2_in;
   logic [TAG_W-1:0] query1_in, query2_in, dest_in;
   logic [TAG_W-1:0] alu_num, mem_num;
   logic [31:0]      alu_value, mem_value;
   logic             issue_ready;
   logic             rs_full, issue_valid;
   logic [4:0]       issue_op;
   logic [31:0]      issue_a, issue_b;
   logic [TAG_W-1:0] issue_dest;

   reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .op_in(op_in),
      .value1_in(value1_in), .value2_in(value2_in),
      .query1_in(query1_in), .query2_in(query2_in), .dest_in(dest_in),
      .alu_num(alu_num), .alu_value(alu_value),
      .mem_num(mem_num), .mem_value(mem_value),
      .issue_ready(issue_ready), .rs_full(rs_full), .issue_valid(issue_valid),
      .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
      .issue_dest(issue_dest)
   );

   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit             valid;
      bit [4:0]       op;
      bit [31:0]      v1, v2;
      bit [TAG_W-1:0] q1, q2, dest;
   } ent_t;

   ent_t           m_ent [DEPTH];
   ent_t           nx_ent[DEPTH];
   bit             m_iv, nx_iv;
   bit [4:0]       m_op, nx_op;
   bit [31:0]      m_a, m_b, nx_a, nx_b;
   bit [TAG_W-1:0] m_dest, nx_dest;

   function automatic bit [TAG_W+31:0] resolve(bit [TAG_W-1:0] q, bit [31:0] v);
      if (q != 0 && q == alu_num) return {{TAG_W{1'b0}}, alu_value};
      if (q != 0 && q == mem_num) return {{TAG_W{1'b0}}, mem_value};
      return {q, v};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_ent[i] = '{default: 0};
      m_iv = 0; m_op = OP_NONE; m_a = 0; m_b = 0; m_dest = 0;
   endtask

   task automatic model_eval();
      int sel = -1;
      int fr  = -1;
      for (int i = 0; i < DEPTH; i++) begin
         nx_ent[i] = m_ent[i];
         if (sel < 0 && m_ent[i].valid && m_ent[i].q1 == 0 && m_ent[i].q2 == 0) sel = i;
         if (fr < 0 && !m_ent[i].valid) fr = i;
         if (m_ent[i].valid) begin
            {nx_ent[i].q1, nx_ent[i].v1} = resolve(m_ent[i].q1, m_ent[i].v1);
            {nx_ent[i].q2, nx_ent[i].v2} = resolve(m_ent[i].q2, m_ent[i].v2);
         end
      end
      nx_iv = m_iv; nx_op = m_op; nx_a = m_a; nx_b = m_b; nx_dest = m_dest;
      if ((!m_iv || issue_ready) && sel >= 0) begin
         nx_iv = 1; nx_op = m_ent[sel].op; nx_a = m_ent[sel].v1;
         nx_b = m_ent[sel].v2; nx_dest = m_ent[sel].dest;
         nx_ent[sel].valid = 0;
      end else if (m_iv && issue_ready) begin
         nx_iv = 0;
      end
      if (op_in != OP_NONE && fr >= 0) begin
         nx_ent[fr].valid = 1;
         nx_ent[fr].op    = op_in;
         nx_ent[fr].dest  = dest_in;
         {nx_ent[fr].q1, nx_ent[fr].v1} = resolve(query1_in, value1_in);
         {nx_ent[fr].q2, nx_ent[fr].v2} = resolve(query2_in, value2_in);
      end
   endtask

   task automatic compare_all();
      int cnt = 0;
      for (int i = 0; i < DEPTH; i++) cnt += int'(m_ent[i].valid);
      check("rs_full", 32'(rs_full), 32'(cnt == DEPTH));
      check("issue_valid", 32'(issue_valid), 32'(m_iv));
      check("issue_op", 32'(issue_op), 32'(m_op));
      check("issue_a", issue_a, m_a);
      check("issue_b", issue_b, m_b);
      check("issue_dest", 32'(issue_dest), 32'(m_dest));
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      op_in = OP_NONE; value1_in = 0; value2_in = 0;
      query1_in = 0; query2_in = 0; dest_in = 1;
      alu_num = 0; alu_value = 0; mem_num = 0; mem_value = 0;
   endtask

   task automatic drive_disp(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                             input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] q2,
                             input logic [TAG_W-1:0] dest);
      op_in = op; value1_in = v1; value2_in = v2;
      query1_in = q1; query2_in = q2; dest_in = dest;
   endtask

   // One clock edge: predict, advance, then compare just after the edge.
   task automatic step();
      model_eval();
      @(posedge clk);
      #1;
      m_ent = nx_ent;
      m_iv = nx_iv; m_op = nx_op; m_a = nx_a; m_b = nx_b; m_dest = nx_dest;
      compare_all();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_full"}, 32'(rs_full), 32'd0);
      check({tag, "_iv"}, 32'(issue_valid), 32'd0);
      check({tag, "_op"}, 32'(issue_op), 32'(OP_NONE));
      check({tag, "_a"}, issue_a, 32'd0);
      check({tag, "_b"}, issue_b, 32'd0);
      check({tag, "_dest"}, 32'(issue_dest), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      issue_ready = 1'b1;
      set_idle();
      model_reset();
      #12;
      check_reset_values("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Ready ADD: issues one edge after dispatch.
      drive_disp(5'b00000, 32'd5, 32'd7, 0, 0, 3'd3);
      step();
      check("add_not_yet", 32'(issue_valid), 32'd0);
      set_idle();
      step();
      check("add_iv", 32'(issue_valid), 32'd1);
      check("add_op", 32'(issue_op), 32'd0);
      check("add_a", issue_a, 32'd5);
      check("add_b", issue_b, 32'd7);
      check("add_dest", 32'(issue_dest), 32'd3);
      step();

      // Waiting on ALU tag 4; wakes only when the broadcast appears.
      drive_disp(5'd2, 32'hFFFF_FFFF, 32'd9, 3'd4, 0, 3'd5);
      step();
      set_idle();
      for (int i = 0; i < 3; i++) begin
         step();
         check("wait_no_issue", 32'(issue_valid), 32'd0);
      end
      alu_num = 3'd4; alu_value = 32'h1234;
      step();
      check("wake_not_yet", 32'(issue_valid), 32'd0);
      set_idle();
      step();
      check("wake_iv", 32'(issue_valid), 32'd1);
      check("wake_a", issue_a, 32'h1234);
      check("wake_b", issue_b, 32'd9);
      step();

      // Same-edge memory broadcast captured at dispatch.
      drive_disp(5'd3, 32'd1, 32'd0, 0, 3'd2, 3'd6);
      mem_num = 3'd2; mem_value = 32'hDEAD;
      step();
      set_idle();
      step();
      check("fwd_iv", 32'(issue_valid), 32'd1);
      check("fwd_b", issue_b, 32'hDEAD);
      step();

      // Fill with issue stalled; 6th dispatch must be dropped.
      issue_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         drive_disp(5'(k), 32'(100 + k), 32'(200 + k), 0, 0, 3'(k));
         step();
         if (k == 4) begin
            check("fill4_full", 32'(rs_full), 32'd0);
            check("fill4_iv", 32'(issue_valid), 32'd1);
         end
         if (k == 5) check("fill5_full", 32'(rs_full), 32'd1);
         if (k == 6) check("fill6_full", 32'(rs_full), 32'd1);
      end
      set_idle();
      issue_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("dropped_never", 32'(issue_valid && issue_a == 32'd106), 32'd0);
      end

      // Async reset with 3 entries valid and an issue pending.
      issue_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         drive_disp(5'd7, 32'(k), 32'(k), 0, 0, 3'(k));
         step();
      end
      set_idle();
      check("pre_rst_iv", 32'(issue_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_reset_values("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_idle", 32'(issue_valid), 32'd0);
      end

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         issue_ready = ($urandom_range(0, 3) != 0);
         op_in       = ($urandom_range(0, 2) == 0) ? OP_NONE : 5'($urandom_range(0, 30));
         value1_in   = $urandom;
         value2_in   = $urandom;
         query1_in   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         query2_in   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         dest_in     = 3'($urandom_range(1, 7));
         alu_num     = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         alu_value   = $urandom;
         mem_num     = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         mem_value   = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
